// File: rtl/demo_switch_player_pkg.sv
// Shared types and helpers for the switch-game demo player.
package game_pkg;

  localparam int NUM_SW = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REACT,
    TOGGLE,
    SETTLE
  } player_state_t;

  // True when exactly one bit is set; all-zero and multi-bit lamps are rejected.
  function automatic logic is_onehot(input logic [NUM_SW-1:0] vec);
    return (vec != '0) && ((vec & (vec - NUM_SW'(1))) == '0);
  endfunction

  // Rotate left by one; the top switch wraps to switch 0.
  function automatic logic [NUM_SW-1:0] rotl1(input logic [NUM_SW-1:0] vec);
    return {vec[NUM_SW-2:0], vec[NUM_SW-1]};
  endfunction

endpackage

// File: rtl/demo_switch_player_delay_counter.sv
// 32-bit load/count-down timer shared by the kick, react and settle phases.
module delay_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_en,
  output logic        o_zero
);

  logic [31:0] r_cnt;

  // Load wins over count; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (!reset_n)                   r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)   r_cnt <= r_cnt - 32'd1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/demo_switch_player.sv
// Attract-mode player: watches the one-hot LED prompt and flips the prompted
// switch after a reaction delay, with a deliberate miss every MISS_EVERY rounds.
module demo_switch_player
  import game_pkg::*;
#(
  parameter int REACT_CYCLES  = 25000000,
  parameter int SETTLE_CYCLES = 1000000,
  parameter int KICK_CYCLES   = 50000000,
  parameter int MISS_EVERY    = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_SW-1:0] led_prompt,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_out,
  output logic              demo_active,
  output logic              busy,
  output logic [7:0]        rounds_played
);

  localparam logic [31:0] REACT_LOAD  = 32'(REACT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] KICK_LOAD   = 32'(KICK_CYCLES - 1);
  localparam logic [7:0]  MISS_LAST   = 8'(MISS_EVERY - 1);

  player_state_t     r_state, w_next;
  logic [NUM_SW-1:0] r_prompt, r_last_prompt, r_tgt, r_sw_out;
  logic [7:0]        r_miss_cnt, r_rounds;
  logic              r_demo_active, r_busy;

  logic              w_load, w_en, w_zero, w_latch, w_fire, w_kick, w_miss;
  logic [31:0]       w_load_val;
  logic              w_onehot, w_new;
  logic [NUM_SW-1:0] w_fire_tgt, w_flip;

  delay_counter u_dly (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_en      (w_en),
    .o_zero    (w_zero)
  );

  // The prompt is registered once so the FSM decides on a stable value;
  // this also gives the prompt-to-REACT step its one-cycle latency.
  assign w_onehot   = is_onehot(r_prompt);
  assign w_new      = w_onehot && (r_prompt != r_last_prompt);
  assign w_fire_tgt = w_kick ? NUM_SW'(1) : r_tgt;
  assign w_miss     = (MISS_EVERY != 0) && (r_miss_cnt == MISS_LAST);
  assign w_flip     = w_miss ? rotl1(w_fire_tgt) : w_fire_tgt;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state and timer control; enable dropping overrides everything.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    w_latch    = 1'b0;
    w_fire     = 1'b0;
    w_kick     = 1'b0;
    if (r_state != IDLE && !enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (enable) begin
          w_next = WAIT; w_load = 1'b1; w_load_val = KICK_LOAD;
        end
        WAIT: begin
          if (w_new) begin
            w_latch = 1'b1; w_load = 1'b1; w_load_val = REACT_LOAD; w_next = REACT;
          end else if (w_zero) begin
            w_kick = 1'b1; w_fire = 1'b1; w_next = TOGGLE;
          end else begin
            w_en = 1'b1;
          end
        end
        REACT: begin
          if (!w_onehot) begin
            w_next = WAIT; w_load = 1'b1; w_load_val = KICK_LOAD;
          end else if (w_new) begin
            w_latch = 1'b1; w_load = 1'b1; w_load_val = REACT_LOAD;
          end else if (w_zero) begin
            w_fire = 1'b1; w_next = TOGGLE;
          end else begin
            w_en = 1'b1;
          end
        end
        TOGGLE: begin
          w_load = 1'b1; w_load_val = SETTLE_LOAD; w_next = SETTLE;
        end
        SETTLE: begin
          if (w_zero) begin
            w_next = WAIT; w_load = 1'b1; w_load_val = KICK_LOAD;
          end else begin
            w_en = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Datapath: the switch flip is registered on the edge that enters TOGGLE,
  // so sw_out moves exactly REACT_CYCLES edges after REACT is entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prompt      <= '0;
      r_last_prompt <= '0;
      r_tgt         <= '0;
      r_sw_out      <= '0;
      r_miss_cnt    <= '0;
      r_rounds      <= '0;
      r_demo_active <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_prompt      <= led_prompt;
      r_demo_active <= (w_next != IDLE);
      // Busy stays continuous across the single toggle cycle.
      r_busy        <= (w_next == REACT) || (w_next == TOGGLE) || (w_next == SETTLE);
      if (r_state == IDLE) r_sw_out <= sw_in;
      if (r_state == IDLE && enable) begin
        r_rounds      <= '0;
        r_miss_cnt    <= '0;
        r_last_prompt <= led_prompt;
      end
      if (w_latch) begin
        r_tgt         <= r_prompt;
        r_last_prompt <= r_prompt;
      end
      if (w_kick) r_tgt <= NUM_SW'(1);
      if (w_fire) begin
        r_sw_out <= r_sw_out ^ w_flip;
        if (w_miss)               r_miss_cnt <= '0;
        else if (MISS_EVERY != 0) r_miss_cnt <= r_miss_cnt + 8'd1;
        if (r_rounds != 8'hFF)    r_rounds   <= r_rounds + 8'd1;
      end
    end
  end

  assign sw_out        = r_sw_out;
  assign demo_active   = r_demo_active;
  assign busy          = r_busy;
  assign rounds_played = r_rounds;

endmodule
